// File: rtl/glove_conditioner.sv
// Per-glove tracker conditioning: EMA coordinate smoothing, closed-hand debounce
// and track-loss detection, with all outputs latched once per frame at vsync fall.
module glove_conditioner #(
    parameter int ALPHA_SHIFT = 2,
    parameter int FRAC        = 4,
    parameter int DEBOUNCE    = 3,
    parameter int LOST_FRAMES = 8
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        sample_valid,
    input  logic [10:0] raw_x,
    input  logic [9:0]  raw_y,
    input  logic        raw_closed,
    output logic [15:0] glove_x,
    output logic [15:0] glove_y,
    output logic        closed,
    output logic        tracking,
    output logic        frame_update
);

    localparam int ACC_W = 12 + FRAC;
    localparam logic [ACC_W:0] HALF = ((ACC_W + 1)'(1) << FRAC) >> 1;

    typedef enum logic {
        LOST     = 1'b0,
        TRACKING = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        vsync_reg;
    logic        frame_start;
    logic        got_sample_reg;
    logic        lose;
    logic        track_eval;
    logic        closed_state_reg;
    logic [3:0]  deb_cnt_reg;
    logic [3:0]  deb_inc;
    logic [7:0]  miss_reg;
    logic [7:0]  miss_inc;
    logic [10:0] raw_ext [2];
    logic [15:0] rounded [2];

    assign raw_ext[0]  = raw_x;
    assign raw_ext[1]  = {1'b0, raw_y};
    assign frame_start = vsync_reg & ~vsync;
    assign miss_inc    = miss_reg + 8'd1;
    assign deb_inc     = deb_cnt_reg + 4'd1;

    // Loss is evaluated before any same-cycle sample, so that sample counts
    // toward the next frame and, if tracking just dropped, reloads unfiltered.
    assign lose       = frame_start && (state_reg == TRACKING) && !got_sample_reg
                        && (miss_inc == 8'(LOST_FRAMES));
    assign track_eval = (state_reg == TRACKING) && !lose;
    assign state_next = (sample_valid || track_eval) ? TRACKING : LOST;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            logic signed [ACC_W-1:0] acc_reg;
            logic signed [ACC_W:0]   target;
            logic signed [ACC_W:0]   diff;
            logic signed [ACC_W:0]   step;
            logic        [ACC_W:0]   sum;

            assign target      = signed'((ACC_W + 1)'(raw_ext[gi]) << FRAC);
            assign diff        = target - {acc_reg[ACC_W-1], acc_reg};
            assign step        = diff >>> ALPHA_SHIFT;
            // Accumulator is a convex mix of in-range samples, never negative.
            assign sum         = {1'b0, acc_reg} + HALF;
            assign rounded[gi] = 16'(sum >> FRAC);

            always_ff @(posedge vclock or negedge reset) begin
                if (!reset) begin
                    acc_reg <= '0;
                end else if (sample_valid) begin
                    if (track_eval) begin
                        acc_reg <= ACC_W'(acc_reg + step);
                    end else begin
                        acc_reg <= ACC_W'(target);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge vclock or negedge reset) begin
        if (!reset) begin
            state_reg        <= LOST;
            vsync_reg        <= 1'b0;
            got_sample_reg   <= 1'b0;
            closed_state_reg <= 1'b0;
            deb_cnt_reg      <= '0;
            miss_reg         <= '0;
            glove_x          <= '0;
            glove_y          <= '0;
            closed           <= 1'b0;
            tracking         <= 1'b0;
            frame_update     <= 1'b0;
        end else begin
            vsync_reg    <= vsync;
            state_reg    <= state_next;
            frame_update <= frame_start;

            if (frame_start) begin
                glove_x  <= rounded[0];
                glove_y  <= rounded[1];
                closed   <= closed_state_reg;
                tracking <= track_eval;
                if (state_reg != TRACKING || got_sample_reg || lose) begin
                    miss_reg <= '0;
                end else begin
                    miss_reg <= miss_inc;
                end
            end

            if (sample_valid) begin
                got_sample_reg <= 1'b1;
            end else if (frame_start) begin
                got_sample_reg <= 1'b0;
            end

            if (sample_valid) begin
                if (!track_eval) begin
                    closed_state_reg <= raw_closed;
                    deb_cnt_reg      <= '0;
                end else if (raw_closed == closed_state_reg) begin
                    deb_cnt_reg <= '0;
                end else if (deb_inc == 4'(DEBOUNCE)) begin
                    closed_state_reg <= ~closed_state_reg;
                    deb_cnt_reg      <= '0;
                end else begin
                    deb_cnt_reg <= deb_inc;
                end
            end
        end
    end

endmodule
